// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants and types for the VGA text-path glyph loader
package vga_pkg;

    localparam logic [1:0] OP_SELECT     = 2'd0;
    localparam logic [1:0] OP_DATA       = 2'd1;
    localparam logic [1:0] OP_FILL_GLYPH = 2'd2;
    localparam logic [1:0] OP_FILL_ALL   = 2'd3;

    localparam int GLYPH_ROWS    = 16;
    localparam int NUM_CHARS     = 128;
    localparam int BITMAP_ADDR_W = 11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } gl_state_t;

endpackage

// File: rtl/glyph_loader.sv
// rtl/glyph_loader.sv - command-driven write sequencer for the character bitmap RAM
//
// Optional feature macro: GLYPH_LOADER_MIRROR_EN (bit-reverse every written byte).
//
// Ports:
//   CLK, RST                   clock, asynchronous active-high reset
//   cmd_valid / cmd_ready      command handshake (ready only while IDLE)
//   cmd_op[1:0], cmd_data[7:0] opcode and operand
//   write_data/addr/strobe     registered bitmap RAM write port, addr = {char, row}
//   busy                       high while a fill is in progress
//   glyph_done                 one-cycle pulse with the write that finishes a glyph
module glyph_loader
    import vga_pkg::*;
(
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [7:0]               cmd_data,
    output logic [7:0]               write_data,
    output logic [BITMAP_ADDR_W-1:0] write_addr,
    output logic                     write_strobe,
    output logic                     busy,
    output logic                     glyph_done
);

    localparam logic [3:0]               LAST_ROW    = 4'(GLYPH_ROWS - 1);
    localparam logic [BITMAP_ADDR_W-1:0] GLYPH_REST  = BITMAP_ADDR_W'(GLYPH_ROWS - 1);
    localparam logic [BITMAP_ADDR_W-1:0] ALL_REST    = BITMAP_ADDR_W'(GLYPH_ROWS * NUM_CHARS - 1);

    function automatic logic [7:0] f_src_to_byte(input logic [7:0] src);
        logic [7:0] v_out;
`ifdef GLYPH_LOADER_MIRROR_EN
        for (int i = 0; i < 8; i++) begin
            v_out[i] = src[7-i];
        end
`else
        v_out = src;
`endif
        return v_out;
    endfunction

    gl_state_t                r_state, w_state_nx;
    // {char_sel, row} kept as one pointer: row 15 -> 0 carries into char_sel,
    // so a single increment covers DATA, FILL_GLYPH and FILL_ALL advancement.
    logic [BITMAP_ADDR_W-1:0] r_ptr, w_ptr_nx;
    // Writes still to issue after the one launched on acceptance.
    logic [BITMAP_ADDR_W-1:0] r_fill_cnt, w_fill_cnt_nx;
    logic [7:0]               r_fill_data, w_fill_data_nx;
    logic [7:0]               w_wdata_nx;
    logic [BITMAP_ADDR_W-1:0] w_waddr_nx;
    logic                     w_strobe_nx;
    logic                     w_done_nx;
    logic                     w_accept;
    logic [7:0]               w_src_byte;

    assign cmd_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_src_byte = f_src_to_byte(cmd_data);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_ptr_nx       = r_ptr;
        w_fill_cnt_nx  = r_fill_cnt;
        w_fill_data_nx = r_fill_data;
        w_strobe_nx    = 1'b0;
        w_waddr_nx     = write_addr;
        w_wdata_nx     = write_data;
        w_done_nx      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        OP_SELECT: begin
                            w_ptr_nx = {cmd_data[6:0], 4'd0};
                        end
                        OP_DATA: begin
                            w_strobe_nx = 1'b1;
                            w_waddr_nx  = r_ptr;
                            w_wdata_nx  = w_src_byte;
                            w_done_nx   = (r_ptr[3:0] == LAST_ROW);
                            w_ptr_nx    = r_ptr + 1'b1;
                        end
                        OP_FILL_GLYPH: begin
                            // Row 0 goes out now; the FILL state streams rows 1..15.
                            w_strobe_nx    = 1'b1;
                            w_waddr_nx     = {r_ptr[10:4], 4'd0};
                            w_wdata_nx     = w_src_byte;
                            w_fill_data_nx = w_src_byte;
                            w_ptr_nx       = {r_ptr[10:4], 4'd1};
                            w_fill_cnt_nx  = GLYPH_REST;
                            w_state_nx     = ST_FILL;
                        end
                        default: begin
                            w_strobe_nx    = 1'b1;
                            w_waddr_nx     = '0;
                            w_wdata_nx     = w_src_byte;
                            w_fill_data_nx = w_src_byte;
                            w_ptr_nx       = BITMAP_ADDR_W'(1);
                            w_fill_cnt_nx  = ALL_REST;
                            w_state_nx     = ST_FILL;
                        end
                    endcase
                end
            end
            default: begin
                w_strobe_nx   = 1'b1;
                w_waddr_nx    = r_ptr;
                w_wdata_nx    = r_fill_data;
                w_ptr_nx      = r_ptr + 1'b1;
                w_fill_cnt_nx = r_fill_cnt - 1'b1;
                // Returning to IDLE together with the last write lets a new
                // command be accepted during it, so streams abut without gaps.
                if (r_fill_cnt == BITMAP_ADDR_W'(1)) begin
                    w_done_nx  = 1'b1;
                    w_state_nx = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ptr        <= '0;
            r_fill_cnt   <= '0;
            r_fill_data  <= '0;
            write_strobe <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
            glyph_done   <= 1'b0;
        end else begin
            r_ptr        <= w_ptr_nx;
            r_fill_cnt   <= w_fill_cnt_nx;
            r_fill_data  <= w_fill_data_nx;
            write_strobe <= w_strobe_nx;
            write_addr   <= w_waddr_nx;
            write_data   <= w_wdata_nx;
            glyph_done   <= w_done_nx;
        end
    end

endmodule

// File: tb/tb_glyph_loader.sv
// tb/tb_glyph_loader.sv - self-checking bench for glyph_loader
module tb_glyph_loader;
    import vga_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic [7:0]  write_data;
    logic [10:0] write_addr;
    logic        write_strobe;
    logic        busy;
    logic        glyph_done;

    glyph_loader dut (
        .CLK          (CLK),
        .RST          (RST),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .write_data   (write_data),
        .write_addr   (write_addr),
        .write_strobe (write_strobe),
        .busy         (busy),
        .glyph_done   (glyph_done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [10:0] addr;
        logic [7:0]  data;
        bit          done;
    } wr_t;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  data;
        bit          wr;
        logic [10:0] addr;
        logic [7:0]  wdata;
        bit          done;
    } vec_t;

    wr_t  sb[$];
    wr_t  pend[$];
    vec_t tbl[36];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [7:0] exp_byte(input logic [7:0] b);
        logic [7:0] t;
`ifdef GLYPH_LOADER_MIRROR_EN
        t = {<<{b}};
`else
        t = b;
`endif
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_fill(input logic [10:0] base, input int cnt, input logic [7:0] d);
        for (int i = 0; i < cnt; i++) begin
            pend.push_back('{addr: base + 11'(i), data: exp_byte(d), done: (i == cnt - 1)});
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [1:0] op, input logic [7:0] d, output int waited);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        waited    = 0;
        while (!cmd_ready && waited < 5000) begin
            @(negedge CLK);
            waited++;
        end
        if (!cmd_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: cmd_ready stayed 0, expected 1");
        end
        while (pend.size() > 0) sb.push_back(pend.pop_front());
        @(negedge CLK);
        cmd_valid = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            if (write_strobe) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", write_addr, write_data);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    check("wr_addr", 32'(write_addr), 32'(e.addr));
                    check("wr_data", 32'(write_data), 32'(e.data));
                    check("wr_done", 32'(glyph_done), 32'(e.done));
                end
            end else if (glyph_done) begin
                n_vec++;
                n_err++;
                $display("FAIL stray_done: glyph_done 1 without a write, expected 0");
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int k;

        k = 0;
        tbl[k++] = '{OP_SELECT, 8'h41, 0, 11'h0, 8'h0, 0};
        for (int i = 0; i < 16; i++)
            tbl[k++] = '{OP_DATA, 8'(i), 1, 11'h410 + 11'(i), 8'(i), (i == 15)};
        tbl[k++] = '{OP_DATA, 8'h5C, 1, 11'h420, 8'h5C, 0};
        tbl[k++] = '{OP_SELECT, 8'hFF, 0, 11'h0, 8'h0, 0};
        for (int i = 0; i < 17; i++)
            tbl[k++] = '{OP_DATA, 8'hC0 + 8'(i), 1,
                         (i < 16) ? 11'h7F0 + 11'(i) : 11'h000, 8'hC0 + 8'(i), (i == 15)};

        RST = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'd0;
        cmd_data = 8'h00;
        repeat (2) @(negedge CLK);
        check("rst_strobe", 32'(write_strobe), 0);
        check("rst_addr",   32'(write_addr),   0);
        check("rst_data",   32'(write_data),   0);
        check("rst_done",   32'(glyph_done),   0);
        check("rst_busy",   32'(busy),         0);
        check("rst_ready",  32'(cmd_ready),    1);
        RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 36; i++) begin
            if (tbl[i].wr)
                pend.push_back('{addr: tbl[i].addr, data: exp_byte(tbl[i].wdata), done: tbl[i].done});
            send(tbl[i].op, tbl[i].data, w);
        end
        repeat (2) @(negedge CLK);
        check("table_drained", 32'(sb.size()), 0);

        // FILL_GLYPH with a DATA command held pending behind it
        send(OP_SELECT, 8'h05, w);
        push_fill(11'h050, 16, 8'hAA);
        send(OP_FILL_GLYPH, 8'hAA, w);
        pend.push_back('{addr: 11'h060, data: exp_byte(8'h11), done: 0});
        send(OP_DATA, 8'h11, w);
        check("fill_ready_low_cycles", 32'(w), 15);
        check("data_after_fill_strobe", 32'(write_strobe), 1);
        check("data_after_fill_addr", 32'(write_addr), 32'h060);

        // FILL_ALL
        push_fill(11'h000, 2048, 8'hFF);
        send(OP_FILL_ALL, 8'hFF, w);
        k = 0;
        while (busy && k < 5000) begin
            k++;
            @(negedge CLK);
        end
        check("fill_all_busy_cycles", 32'(k), 2047);
        @(negedge CLK);
        check("fill_all_busy_after", 32'(busy), 0);
        check("fill_all_drained", 32'(sb.size()), 0);
        pend.push_back('{addr: 11'h000, data: exp_byte(8'h3C), done: 0});
        send(OP_DATA, 8'h3C, w);

        // Reset during the 8th write of a FILL_GLYPH
        send(OP_SELECT, 8'h33, w);
        push_fill(11'h330, 16, 8'h5A);
        send(OP_FILL_GLYPH, 8'h5A, w);
        repeat (7) @(negedge CLK);
        check("pre_rst_addr", 32'(write_addr), 32'h337);
        #1 RST = 1'b1;
        #1;
        check("midrst_strobe", 32'(write_strobe), 0);
        check("midrst_busy", 32'(busy), 0);
        sb.delete();
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("post_rst_ready", 32'(cmd_ready), 1);
        @(negedge CLK);
        pend.push_back('{addr: 11'h000, data: exp_byte(8'h77), done: 0});
        send(OP_DATA, 8'h77, w);

        // Bit-order check (0x80 when mirroring is built in)
        pend.push_back('{addr: 11'h001, data: exp_byte(8'h01), done: 0});
        send(OP_DATA, 8'h01, w);

        repeat (3) @(negedge CLK);
        check("final_drained", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/glyph_loader.md
# glyph_loader

Command-driven write sequencer for the character bitmap RAM in the VGA text path. It accepts glyph-upload commands from the CPU-side bus over a valid/ready handshake and turns each one into registered byte writes on the bitmap RAM's write port (`write_data`, `write_addr`, `write_strobe`). It tracks the current character and row so the CPU can stream a whole font, and it supports single-glyph and whole-RAM fill operations.

## Interface
- No parameters. The geometry is fixed: 128 characters × 16 rows × 8 bits, giving an 11-bit address `{char, row}`.
- `CLK` in 1 — system clock; all logic on posedge.
- `RST` in 1 — asynchronous, active-high reset.
- `cmd_valid` in 1 — a command is presented.
- `cmd_ready` out 1 — the block can accept a command; it is high only in the IDLE state.
- `cmd_op` in 2 — command opcode:
  - 0 = SELECT
  - 1 = DATA
  - 2 = FILL_GLYPH
  - 3 = FILL_ALL
- `cmd_data` in 8 — command operand.
- `write_data` out 8 — byte to the bitmap RAM.
- `write_addr` out 11 — address to the bitmap RAM, `{char[6:0], row[3:0]}`.
- `write_strobe` out 1 — write enable to the bitmap RAM.
- `busy` out 1 — high when the state is not IDLE.
- `glyph_done` out 1 — one-cycle pulse marking the last row of a glyph being written.

## Operation
- Internal registers: `char_sel[6:0]`, `row[3:0]`, `fill_cnt[10:0]`, and the state (IDLE, FILL).
- A command is accepted on a rising edge where `cmd_valid && cmd_ready`.
- **SELECT**
  - `char_sel <= cmd_data[6:0]`, `row <= 0`.
  - `cmd_data[7]` is ignored. No write is issued.
- **DATA**
  - Issues one write: `write_data = cmd_data`, `write_addr = {char_sel, row}`.
  - Then `row` increments.
  - When the write is to row 15, `row` wraps to 0, `char_sel` increments (127 wraps to 0) and `glyph_done` pulses.
- **FILL_GLYPH**
  - The state goes to FILL and issues 16 writes of `cmd_data` to `{char_sel, 0..15}` on consecutive cycles.
  - On completion: `row = 0`, `char_sel` advanced by 1 (with wrap), `glyph_done` pulsed with the row-15 write.
- **FILL_ALL**
  - Issues 2048 writes of `cmd_data` to addresses 0..2047 in order.
  - On completion: `char_sel = 0`, `row = 0`, and `glyph_done` pulses once with the write to address 2047.
- Writes are only ever issued by accepted commands; there is no read path.
- A byte is stored exactly as it appears on `write_data`. Bit *n* is pixel column *x = n*.

## Timing
- Reset values: state IDLE, `write_strobe` 0, `write_addr` 0, `write_data` 0, `glyph_done` 0, `busy` 0, `char_sel` 0, `row` 0, `cmd_ready` 1.
  - `cmd_ready` and `busy` are decoded from the state.
  - All other outputs are registered.
- Write latency: for a DATA command accepted at edge *k*, `write_strobe` is high during cycle *k+1* only, with address and data stable throughout that cycle.
- FILL_GLYPH accepted at edge *k*:
  - Strobes are high in cycles *k+1* through *k+16*, addresses row 0 through row 15.
  - `cmd_ready` is low in cycles *k+1* through *k+15* and high in cycle *k+16*, the final write.
  - A command accepted at edge *k+16* produces its write in cycle *k+17*, so there are no gaps or overlaps.
- FILL_ALL: same pattern as FILL_GLYPH with 2048 writes; `cmd_ready` is low in cycles *k+1* through *k+2047*.
- Back-to-back DATA commands sustain one write per cycle.
- `cmd_valid` while `cmd_ready` is low: ignored, and the command stays pending at the source.
- Reset mid-fill: outputs go to reset values immediately (asynchronous). RAM contents already written remain. There is no resume.

## Configuration
- **`GLYPH_LOADER_MIRROR_EN`**
  - Defined: every written byte is bit-reversed, so that `write_data[7-n] = source[n]`. The CPU can then supply MSB-leftmost font data. This applies to DATA, FILL_GLYPH and FILL_ALL.
  - Undefined: bytes pass through unchanged.

## Structure
- Shared package `vga_pkg`:
  - Opcode constants `OP_SELECT`, `OP_DATA`, `OP_FILL_GLYPH`, `OP_FILL_ALL`.
  - `GLYPH_ROWS = 16`, `NUM_CHARS = 128`, `BITMAP_ADDR_W = 11`.
- A single module, with no sub-module. The optional mirror function is a local function inside the module.

## Test plan
- Reset, then SELECT 0x41, then 16 DATA bytes 0x00..0x0F:
  - Expect 16 strobes at addresses 0x410..0x41F with data 0x00..0x0F.
  - Expect `glyph_done` in the 16th write cycle.
  - A following DATA byte writes to 0x420.
- SELECT 0x7F, then 17 DATA commands: the 17th write goes to address 0x000 (character wraps 127 to 0).
- SELECT 0x05, then FILL_GLYPH 0xAA, with `cmd_valid` held high on a DATA 0x11 command:
  - Expect strobes at 0x050..0x05F with data 0xAA and `cmd_ready` low for 15 cycles.
  - The DATA write lands at 0x060 in the cycle immediately after.
- FILL_ALL 0xFF: expect 2048 consecutive strobes, addresses 0..2047, a single `glyph_done`, and `busy` low afterwards.
- Assert `RST` at the 8th write of FILL_GLYPH:
  - Expect `write_strobe` 0 immediately and `cmd_ready` 1 after reset release.
  - SELECT state reset: the next DATA writes to 0x000.
- With `GLYPH_LOADER_MIRROR_EN` defined: DATA 0x01 produces `write_data` 0x80.
